// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow E/M scoreboard, operand-forward selects,
// load-use stall, decode-branch redirect/flush and memory-wait freeze.
module hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              validD,
  input  logic [REG_AW-1:0] ra1D,
  input  logic [REG_AW-1:0] ra2D,
  input  logic              use1D,
  input  logic              use2D,
  input  logic [REG_AW-1:0] dstD,
  input  logic              regwriteD,
  input  logic              memreadD,
  input  logic              branchD,
  input  logic [ADDR_W-1:0] pcbranchD,
  input  logic              i_wait,
  input  logic              d_wait,
  output logic [1:0]        ac,
  output logic [1:0]        bc,
  output logic              stallF,
  output logic              stallD,
  output logic              bubbleE,
  output logic              stallEM,
  output logic              flushD,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              e_valid, e_regwrite, e_memread;
  logic [REG_AW-1:0] e_dst;
  logic              m_valid, m_regwrite, m_memread;
  logic [REG_AW-1:0] m_dst;

  logic              pending;
  logic [ADDR_W-1:0] pend_pc;

  logic e_prod1, e_prod2, m_prod1, m_prod2;
  logic loaduse, branch_now;

  // A load sitting in E cannot forward yet, so its match falls through to M.
  function automatic logic [1:0] fwd_sel(input logic use_r, input logic nz,
                                         input logic e_prod, input logic e_ld,
                                         input logic m_prod, input logic m_ld);
    logic [1:0] sel;
    sel = 2'd0;
    if (use_r && nz) begin
      if (e_prod && !e_ld)  sel = 2'd1;
      else if (m_prod)      sel = m_ld ? 2'd3 : 2'd2;
    end
    return sel;
  endfunction

  always_comb begin
    e_prod1 = e_valid & e_regwrite & (e_dst == ra1D) & (ra1D != '0);
    e_prod2 = e_valid & e_regwrite & (e_dst == ra2D) & (ra2D != '0);
    m_prod1 = m_valid & m_regwrite & (m_dst == ra1D) & (ra1D != '0);
    m_prod2 = m_valid & m_regwrite & (m_dst == ra2D) & (ra2D != '0);

    ac = fwd_sel(use1D, ra1D != '0, e_prod1, e_memread, m_prod1, m_memread);
    bc = fwd_sel(use2D, ra2D != '0, e_prod2, e_memread, m_prod2, m_memread);

    loaduse = validD & e_memread & ((use1D & e_prod1) | (use2D & e_prod2));
  end

  always_comb begin
    stallF     = 1'b0;
    stallD     = 1'b0;
    bubbleE    = 1'b0;
    stallEM    = 1'b0;
    branch_now = 1'b0;
    if (d_wait) begin
      stallF  = 1'b1;
      stallD  = 1'b1;
      stallEM = 1'b1;
    end else if (loaduse) begin
      stallF  = 1'b1;
      stallD  = 1'b1;
      bubbleE = 1'b1;
    end else begin
      stallF     = i_wait;
      branch_now = validD & branchD;
    end
    flushD      = pending | (~d_wait & ~loaduse & (i_wait | branch_now));
    redirect    = pending | branch_now;
    redirect_pc = pending ? pend_pc : (branch_now ? pcbranchD : pend_pc);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_valid    <= 1'b0;
      e_regwrite <= 1'b0;
      e_memread  <= 1'b0;
      e_dst      <= '0;
      m_valid    <= 1'b0;
      m_regwrite <= 1'b0;
      m_memread  <= 1'b0;
      m_dst      <= '0;
    end else if (!d_wait) begin
      m_valid    <= e_valid;
      m_regwrite <= e_regwrite;
      m_memread  <= e_memread;
      m_dst      <= e_dst;
      if (loaduse) begin
        e_valid <= 1'b0;
      end else begin
        e_valid    <= validD & ~flushD;
        e_regwrite <= regwriteD;
        e_memread  <= memreadD;
        e_dst      <= dstD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      pend_pc <= '0;
    end else if (pending) begin
      if (!i_wait) pending <= 1'b0;
    end else if (branch_now && i_wait) begin
      pending <= 1'b1;
      pend_pc <= pcbranchD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      stall_cnt <= '0;
    else if (stallF) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// cycles checked against a stage-list reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        validD, use1D, use2D, regwriteD, memreadD, branchD, i_wait, d_wait;
  logic [4:0]  ra1D, ra2D, dstD;
  logic [63:0] pcbranchD;
  logic [1:0]  ac, bc;
  logic        stallF, stallD, bubbleE, stallEM, flushD, redirect;
  logic [63:0] redirect_pc;
  logic [31:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.REG_AW(5), .ADDR_W(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .validD(validD), .ra1D(ra1D), .ra2D(ra2D),
    .use1D(use1D), .use2D(use2D), .dstD(dstD), .regwriteD(regwriteD),
    .memreadD(memreadD), .branchD(branchD), .pcbranchD(pcbranchD),
    .i_wait(i_wait), .d_wait(d_wait), .ac(ac), .bc(bc), .stallF(stallF),
    .stallD(stallD), .bubbleE(bubbleE), .stallEM(stallEM), .flushD(flushD),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: list of in-flight instructions, index 0 = E, 1 = M.
  typedef struct packed { bit v; bit [4:0] d; bit rw; bit mr; } rec_t;
  rec_t        stg [2];
  bit          r_pend;
  logic [63:0] r_ppc;
  logic [31:0] r_cnt;
  logic [1:0]  x_ac, x_bc;
  bit          x_sF, x_sD, x_bE, x_sEM, x_fD, x_rd, x_lu, x_br;
  logic [63:0] x_pc;

  function automatic bit writes(input rec_t s, input logic [4:0] r);
    return s.v && s.rw && s.d == r && r != 5'd0;
  endfunction

  function automatic logic [1:0] ref_sel(input bit u, input logic [4:0] r);
    if (!u || r == 5'd0) return 2'd0;
    if (writes(stg[0], r) && !stg[0].mr) return 2'd1;
    if (writes(stg[1], r)) return stg[1].mr ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  task automatic ref_reset();
    stg[0] = '0; stg[1] = '0; r_pend = 0; r_ppc = '0; r_cnt = '0;
  endtask

  task automatic ref_eval();
    x_ac = ref_sel(use1D, ra1D);
    x_bc = ref_sel(use2D, ra2D);
    x_lu = validD && stg[0].mr &&
           ((use1D && writes(stg[0], ra1D)) || (use2D && writes(stg[0], ra2D)));
    x_sF = 0; x_sD = 0; x_bE = 0; x_sEM = 0; x_br = 0;
    if (d_wait) begin
      x_sF = 1; x_sD = 1; x_sEM = 1;
    end else if (x_lu) begin
      x_sF = 1; x_sD = 1; x_bE = 1;
    end else begin
      x_sF = i_wait;
      x_br = validD && branchD;
    end
    x_fD = r_pend || (!d_wait && !x_lu && (i_wait || x_br));
    x_rd = r_pend || x_br;
    x_pc = r_pend ? r_ppc : pcbranchD;
  endtask

  task automatic ref_commit();
    if (x_sF) r_cnt = r_cnt + 1;
    if (r_pend) begin
      if (!i_wait) r_pend = 0;
    end else if (x_br && i_wait) begin
      r_pend = 1; r_ppc = pcbranchD;
    end
    if (!d_wait) begin
      stg[1] = stg[0];
      if (x_lu) stg[0].v = 0;
      else stg[0] = '{v: validD && !x_fD, d: dstD, rw: regwriteD, mr: memreadD};
    end
  endtask

  task automatic idle_inputs();
    validD = 0; use1D = 0; use2D = 0; regwriteD = 0; memreadD = 0; branchD = 0;
    i_wait = 0; d_wait = 0; ra1D = '0; ra2D = '0; dstD = '0; pcbranchD = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    tick();
    reset = 1;
    #1;
  endtask

  task automatic drive_instr(input logic [4:0] d, input bit rw, input bit mr);
    idle_inputs();
    validD = 1; dstD = d; regwriteD = rw; memreadD = mr;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    #3;
    checks++; if (ac !== 2'd0 || bc !== 2'd0) begin errors++; $display("FAIL reset_sel ac=%0d bc=%0d want 0/0", ac, bc); end
    checks++; if ({stallF, stallD, bubbleE, stallEM, flushD, redirect} !== 6'b0) begin errors++; $display("FAIL reset_ctl got=%b want 000000", {stallF, stallD, bubbleE, stallEM, flushD, redirect}); end
    checks++; if (redirect_pc !== 64'd0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_regs pc=%h cnt=%0d want 0/0", redirect_pc, stall_cnt); end
    tick();
    reset = 1;
    #1;
  endtask

  task automatic test_forward();
    do_reset();
    drive_instr(5'd5, 1, 0);
    tick();
    idle_inputs();
    validD = 1; use1D = 1; ra1D = 5'd5; use2D = 1; ra2D = 5'd7;
    #1;
    checks++; if (ac !== 2'd1 || bc !== 2'd0) begin errors++; $display("FAIL fwd_E ac=%0d bc=%0d want 1/0", ac, bc); end
    checks++; if (stallF !== 1'b0 || bubbleE !== 1'b0) begin errors++; $display("FAIL fwd_E_nostall stallF=%b bubbleE=%b want 0/0", stallF, bubbleE); end
    tick();
    checks++; if (ac !== 2'd2) begin errors++; $display("FAIL fwd_M ac=%0d want 2", ac); end
  endtask

  task automatic test_loaduse();
    do_reset();
    drive_instr(5'd6, 1, 1);
    tick();
    idle_inputs();
    validD = 1; use2D = 1; ra2D = 5'd6;
    #1;
    checks++; if ({stallF, stallD, bubbleE, stallEM} !== 4'b1110) begin errors++; $display("FAIL lu_stall got=%b want 1110", {stallF, stallD, bubbleE, stallEM}); end
    tick();
    checks++; if ({stallF, stallD, bubbleE} !== 3'b000) begin errors++; $display("FAIL lu_release got=%b want 000", {stallF, stallD, bubbleE}); end
    checks++; if (bc !== 2'd3) begin errors++; $display("FAIL lu_bc bc=%0d want 3", bc); end
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt cnt=%0d want 1", stall_cnt); end
  endtask

  task automatic test_x0();
    do_reset();
    drive_instr(5'd0, 1, 1);
    tick();
    idle_inputs();
    validD = 1; use1D = 1; ra1D = 5'd0;
    #1;
    checks++; if (ac !== 2'd0) begin errors++; $display("FAIL x0_ac ac=%0d want 0", ac); end
    checks++; if (stallF !== 1'b0 || bubbleE !== 1'b0) begin errors++; $display("FAIL x0_stall stallF=%b bubbleE=%b want 0/0", stallF, bubbleE); end
  endtask

  task automatic test_branch_iwait();
    do_reset();
    validD = 1; branchD = 1; pcbranchD = 64'h8000_0100; i_wait = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (redirect !== 1'b1 || redirect_pc !== 64'h8000_0100) begin errors++; $display("FAIL br_hold%0d redirect=%b pc=%h want 1/80000100", i, redirect, redirect_pc); end
      checks++; if (flushD !== 1'b1) begin errors++; $display("FAIL br_flush%0d flushD=%b want 1", i, flushD); end
      tick();
      idle_inputs();
      i_wait = (i < 2);
    end
    #1;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 64'h8000_0100) begin errors++; $display("FAIL br_release redirect=%b pc=%h want 1/80000100", redirect, redirect_pc); end
    tick();
    checks++; if (redirect !== 1'b0 || flushD !== 1'b0) begin errors++; $display("FAIL br_clear redirect=%b flushD=%b want 0/0", redirect, flushD); end
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL br_cnt cnt=%0d want 3", stall_cnt); end
  endtask

  task automatic test_dwait_loaduse();
    do_reset();
    drive_instr(5'd6, 1, 1);
    tick();
    idle_inputs();
    validD = 1; use1D = 1; ra1D = 5'd6; d_wait = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({stallF, stallD, stallEM, bubbleE} !== 4'b1110) begin errors++; $display("FAIL dw_freeze%0d got=%b want 1110", i, {stallF, stallD, stallEM, bubbleE}); end
      tick();
    end
    d_wait = 0;
    #1;
    checks++; if (bubbleE !== 1'b1 || stallEM !== 1'b0) begin errors++; $display("FAIL dw_bubble bubbleE=%b stallEM=%b want 1/0", bubbleE, stallEM); end
    checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL dw_cnt4 cnt=%0d want 4", stall_cnt); end
    tick();
    checks++; if (ac !== 2'd3 || bubbleE !== 1'b0) begin errors++; $display("FAIL dw_after ac=%0d bubbleE=%b want 3/0", ac, bubbleE); end
    checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL dw_cnt5 cnt=%0d want 5", stall_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_instr(5'd9, 1, 0);
    tick();
    idle_inputs();
    validD = 1; branchD = 1; pcbranchD = 64'h1234; i_wait = 1;
    tick();
    idle_inputs();
    i_wait = 0; use1D = 1; ra1D = 5'd9; use2D = 1; ra2D = 5'd9;
    #2;
    reset = 0;
    #1;
    checks++; if (redirect !== 1'b0 || flushD !== 1'b0) begin errors++; $display("FAIL rmid_redirect redirect=%b flushD=%b want 0/0", redirect, flushD); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rmid_cnt cnt=%0d want 0", stall_cnt); end
    checks++; if (ac !== 2'd0 || bc !== 2'd0) begin errors++; $display("FAIL rmid_sel ac=%0d bc=%0d want 0/0", ac, bc); end
    tick();
    reset = 1;
    #1;
  endtask

  task automatic test_random();
    do_reset();
    ref_reset();
    for (int n = 0; n < 400; n++) begin
      validD    = r_pend ? 1'b0 : ($urandom_range(3) != 0);
      ra1D      = 5'($urandom_range(3));
      ra2D      = 5'($urandom_range(3));
      use1D     = $urandom_range(1);
      use2D     = $urandom_range(1);
      dstD      = 5'($urandom_range(3));
      regwriteD = $urandom_range(3) != 0;
      memreadD  = $urandom_range(2) == 0;
      branchD   = $urandom_range(7) == 0;
      pcbranchD = {$urandom, $urandom};
      i_wait    = $urandom_range(3) == 0;
      d_wait    = $urandom_range(7) == 0;
      #1;
      ref_eval();
      checks++; if (ac !== x_ac || bc !== x_bc) begin errors++; $display("FAIL rnd_sel n=%0d ac=%0d bc=%0d want %0d/%0d", n, ac, bc, x_ac, x_bc); end
      checks++; if ({stallF, stallD, bubbleE, stallEM} !== {x_sF, x_sD, x_bE, x_sEM}) begin errors++; $display("FAIL rnd_stall n=%0d got=%b want %b", n, {stallF, stallD, bubbleE, stallEM}, {x_sF, x_sD, x_bE, x_sEM}); end
      checks++; if (flushD !== x_fD || redirect !== x_rd) begin errors++; $display("FAIL rnd_flow n=%0d flushD=%b redirect=%b want %b/%b", n, flushD, redirect, x_fD, x_rd); end
      if (x_rd) begin
        checks++; if (redirect_pc !== x_pc) begin errors++; $display("FAIL rnd_pc n=%0d pc=%h want %h", n, redirect_pc, x_pc); end
      end
      checks++; if (stall_cnt !== r_cnt) begin errors++; $display("FAIL rnd_cnt n=%0d cnt=%0d want %0d", n, stall_cnt, r_cnt); end
      ref_commit();
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    test_reset();
    test_forward();
    test_loaduse();
    test_x0();
    test_branch_iwait();
    test_dwait_loaduse();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core (F/D/E/M/W).
- Keeps its own shadow scoreboard of the instructions in E and M, and from it drives the decode operand-forwarding selects (sctlD.ac / sctlD.bc).
- Also produces load-use stalls and decode-branch redirect/flush, and freezes the pipeline on instruction-memory or data-memory wait.
- Sits beside the datapath; decode consumes its selects and the branch result, and fetch consumes its redirect.

Parameters:
- REG_AW, 5, register address width.
- ADDR_W, 64, PC width.
- CNT_W, 32, stall performance counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- validD  in  1  decode holds a valid instruction
- ra1D  in  REG_AW  decode source register 1
- ra2D  in  REG_AW  decode source register 2
- use1D  in  1  instruction reads ra1
- use2D  in  1  instruction reads ra2
- dstD  in  REG_AW  decode destination register
- regwriteD  in  1  instruction writes dst
- memreadD  in  1  instruction is a load
- branchD  in  1  decode resolved taken branch/jump
- pcbranchD  in  ADDR_W  taken target
- i_wait  in  1  instruction memory busy this cycle
- d_wait  in  1  data memory busy this cycle (M stage)
- ac  out  2  srca select: 0 RD, 1 ALUOUTE, 2 ALUOUTM, 3 MEMDATA
- bc  out  2  srcb select, same encoding
- stallF  out  1  hold PC / fetch register
- stallD  out  1  hold F->D register
- bubbleE  out  1  insert invalid instruction into E
- stallEM  out  1  hold D->E and E->M registers; W receives a bubble
- flushD  out  1  invalidate the F->D register on next edge
- redirect  out  1  fetch must load redirect_pc
- redirect_pc  out  ADDR_W  target PC
- stall_cnt  out  CNT_W  cycles in which stallF was 1

Behaviour:
- Reset (async, reset=0): E/M shadow records invalid; redirect pending clear; redirect_pc=0; stall_cnt=0. Combinational outputs evaluate with invalid records: ac=bc=0, all stall/flush outputs 0.
- Shadow record per stage: {valid, dst, regwrite, memread}.
- A stage "produces r" when valid & regwrite & dst==r & r!=0.
- Forward select per source (use=1, r=ra):
  - E produces r and E is not a load -> 1.
  - Else M produces r: load -> 3, non-load -> 2.
  - Otherwise 0.
  - E takes priority over M. Source with use=0 or r=0 -> 0.
- loaduse = validD & any used source produced by E with E.memread.
- Priority of control conditions, highest first:
  - d_wait: stallF, stallD and stallEM all 1. Shadow records hold. Branch is ignored this cycle and sampled again next cycle.
  - loaduse: stallF=stallD=1, bubbleE=1. Next edge: E<=invalid, M<=E. branchD is ignored, because its operands are not ready.
  - Normal: E<=D record (valid=validD & ~flushD_now), M<=E.
- i_wait alone: stallF=1. D advances, and flushD=1 so an invalid instruction enters D (fetch bubble).
- Branch (normal cycle, validD & branchD):
  - flushD=1 (kills the wrong-path instruction in F).
  - If i_wait=0: redirect=1 and redirect_pc=pcbranchD in the same cycle.
  - If i_wait=1: latch a pending redirect with pcbranchD. Hold redirect=1 and redirect_pc until the first cycle with i_wait=0, then clear on that edge.
  - While a redirect is pending, flushD=1 each cycle, so no wrong-path instruction enters D.
  - A new branch cannot occur while pending, because D only holds bubbles.
- stall_cnt increments each cycle stallF=1 and wraps at 2^CNT_W.
- Reset mid-operation discards the pending redirect and the records immediately.

Test Plan:
- add x5 in E, D reads x5 on rs1 -> ac=1, bc=0, no stall; same producer in M instead -> ac=2.
- ld x6 in E, D uses x6 on rs2 -> stallF=stallD=bubbleE=1 for exactly 1 cycle, then bc=3 with the load in M.
- D reads x0 while E writes x0 -> ac=0, no stall.
- Taken branch to 0x8000_0100 with i_wait=1 for 3 cycles -> redirect=1 and redirect_pc=0x80000100 held all 3 cycles; flushD=1 each cycle; redirect clears after the first i_wait=0 cycle.
- d_wait=1 for 4 cycles concurrent with loaduse -> stallEM=1, shadow records unchanged, stall_cnt +4; the load-use bubble is inserted only after d_wait drops.
- Assert reset=0 with a redirect pending -> redirect=0 immediately, stall_cnt=0, ac=bc=0.
